cud_arbiter_seq: RTL and testbench

- Shares the 2-bit up/down counter (bitCount_UD_addG style: direction input x, output q, G-block flag L) between two requesters.
- Each requester issues a command: direction plus step count.
- The block arbitrates round-robin and sequences the counter's direction and count-enable for the granted number of clocks.
- It stops early when the counter's limit flag fires, then reports completion.

---
 rtl/cud_arbiter_seq.sv | 112 +++++++++++
 tb/tb_cud_arbiter_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cud_arbiter_seq.sv
// Round-robin arbiter that grants one of two requesters the shared up/down counter
// and drives its direction and count-enable for the requested number of steps.
module cud_arbiter_seq #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned STEPW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [STEPW-1:0] req0_steps,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [STEPW-1:0] req1_steps,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_l,
  output logic             cnt_x,
  output logic             cnt_en,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             done_id,
  output logic             done_sat,
  output logic [WIDTH-1:0] done_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             rr_q;
  logic             dir_q;
  logic             gid_q;
  logic             sat_q;
  logic [STEPW-1:0] rem_q;

  logic             any_valid_c;
  logic             win_c;
  logic             hs_c;
  logic             win_dir_c;
  logic [STEPW-1:0] win_steps_c;

  // Winner: the lone valid requester, or the one rr points at when both are valid.
  always_comb begin
    any_valid_c = req0_valid | req1_valid;
    win_c       = (req0_valid & req1_valid) ? rr_q : req1_valid;
    hs_c        = (state_q == IDLE) & any_valid_c;
    win_dir_c   = win_c ? req1_dir : req0_dir;
    win_steps_c = win_c ? req1_steps : req0_steps;
  end

  assign req0_ready = hs_c & ~win_c;
  assign req1_ready = hs_c & win_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      dir_q   <= 1'b0;
      gid_q   <= 1'b0;
      sat_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_c) begin
            dir_q   <= win_dir_c;
            gid_q   <= win_c;
            rr_q    <= ~win_c;
            rem_q   <= win_steps_c;
            sat_q   <= 1'b0;
            state_q <= (win_steps_c == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // A limit hit stalls the counter and ends the command early.
          if (cnt_l) begin
            sat_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            rem_q <= rem_q - STEPW'(1);
            if (rem_q == STEPW'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The final enable lands on the edge into DONE, so cnt_q is passed through live.
  assign cnt_x    = dir_q;
  assign cnt_en   = (state_q == RUN) & ~cnt_l;
  assign busy     = (state_q == RUN);
  assign grant_id = gid_q;
  assign done     = (state_q == DONE);
  assign done_id  = done & gid_q;
  assign done_sat = done & sat_q;
  assign done_q   = done ? cnt_q : '0;

endmodule

// File: tb/tb_cud_arbiter_seq.sv
// Directed bench for cud_arbiter_seq with a 2-bit up/down counter model as its load.
module tb_cud_arbiter_seq;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned STEPW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_dir, req0_ready;
  logic [STEPW-1:0] req0_steps;
  logic             req1_valid, req1_dir, req1_ready;
  logic [STEPW-1:0] req1_steps;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_l;
  logic             cnt_x, cnt_en, busy, grant_id;
  logic             done, done_id, done_sat;
  logic [WIDTH-1:0] done_q;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;

  int checks = 0;
  int errors = 0;

  int r_rdy, r_en, r_x, r_lat, r_id, r_sat, r_q, r_got;

  cud_arbiter_seq #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_steps(req0_steps), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_steps(req1_steps), .req1_ready(req1_ready),
    .cnt_q(cnt_q), .cnt_l(cnt_l), .cnt_x(cnt_x), .cnt_en(cnt_en),
    .busy(busy), .grant_id(grant_id), .done(done), .done_id(done_id),
    .done_sat(done_sat), .done_q(done_q)
  );

  always #5 clk = ~clk;

  // 2-bit up/down counter with terminal-value flag for the current direction.
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_load_val;
    else if (cnt_en) cnt_q <= cnt_x ? cnt_q + 2'd1 : cnt_q - 2'd1;
  end
  assign cnt_l = cnt_x ? (cnt_q == 2'd3) : (cnt_q == 2'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [WIDTH-1:0] v);
    cnt_load = 1'b1;
    cnt_load_val = v;
    tick();
    cnt_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64; i++) begin
      if (done) return;
      tick();
    end
    check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  // Issues one command from a lone requester and records what happens until done.
  task automatic run_cmd(input bit id, input bit dir, input logic [STEPW-1:0] steps);
    logic rdy;
    logic hs;
    r_rdy = 0; r_en = 0; r_x = 0; r_lat = 0; r_id = -1; r_sat = -1; r_q = -1; r_got = 0;
    if (id) begin req1_valid = 1'b1; req1_dir = dir; req1_steps = steps; end
    else    begin req0_valid = 1'b1; req0_dir = dir; req0_steps = steps; end
    #0;
    for (int i = 0; i < 64; i++) begin
      rdy = id ? req1_ready : req0_ready;
      if (rdy) r_rdy++;
      if (cnt_en) begin
        r_en++;
        if (cnt_x == dir) r_x++;
      end
      if (done) begin
        r_id = int'(done_id); r_sat = int'(done_sat); r_q = int'(done_q); r_got = 1;
        break;
      end
      hs = rdy;
      tick();
      r_lat++;
      if (hs) begin
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
      end
    end
    check("run_cmd_got_done", 32'(r_got), 32'd1);
    tick();
  endtask

  int ndone;

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_dir = 0; req0_steps = '0;
    req1_valid = 0; req1_dir = 0; req1_steps = '0;
    cnt_load = 0; cnt_load_val = '0;

    // Test 1: reset values, then req0 up 3 from 0
    do_reset();
    reset = 1'b0; tick();
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt_x", 32'(cnt_x), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_done_q", 32'(done_q), 0);
    check("rst_ready0", 32'(req0_ready), 0);
    reset = 1'b1;
    load_cnt(2'd0);
    run_cmd(1'b0, 1'b1, 4'd3);
    check("t1_ready_pulses", 32'(r_rdy), 1);
    check("t1_en_cycles", 32'(r_en), 3);
    check("t1_x_up", 32'(r_x), 3);
    check("t1_latency", 32'(r_lat), 4);
    check("t1_done_id", 32'(r_id), 0);
    check("t1_done_q", 32'(r_q), 3);
    check("t1_done_sat", 32'(r_sat), 0);

    // Test 2: simultaneous requests, rr alternation
    do_reset();
    load_cnt(2'd0);
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd1;
    req1_valid = 1; req1_dir = 0; req1_steps = 4'd1;
    #0;
    check("t2_rdy0_first", 32'(req0_ready), 1);
    check("t2_rdy1_first", 32'(req1_ready), 0);
    tick();
    check("t2_busy", 32'(busy), 1);
    check("t2_grant0", 32'(grant_id), 0);
    check("t2_rdy0_run", 32'(req0_ready), 0);
    check("t2_rdy1_run", 32'(req1_ready), 0);
    wait_done();
    check("t2_done_id0", 32'(done_id), 0);
    check("t2_done_q0", 32'(done_q), 1);
    check("t2_rdy1_done", 32'(req1_ready), 0);
    tick();
    check("t2_rdy1_rr", 32'(req1_ready), 1);
    check("t2_rdy0_rr", 32'(req0_ready), 0);
    tick();
    req1_valid = 0;
    check("t2_cnt_x_down", 32'(cnt_x), 0);
    wait_done();
    check("t2_done_id1", 32'(done_id), 1);
    check("t2_done_q1", 32'(done_q), 0);
    tick();
    req1_valid = 1;
    #0;
    check("t2_rdy0_rr_back", 32'(req0_ready), 1);
    check("t2_rdy1_rr_back", 32'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_done();
    tick();

    // Test 3: req1 up 5 from 1 saturates after 2 enables
    load_cnt(2'd1);
    run_cmd(1'b1, 1'b1, 4'd5);
    check("t3_en_cycles", 32'(r_en), 2);
    check("t3_done_id", 32'(r_id), 1);
    check("t3_done_sat", 32'(r_sat), 1);
    check("t3_done_q", 32'(r_q), 3);
    check("t3_no_en_after", 32'(cnt_en), 0);

    // Test 4: zero-step command completes right after the handshake
    load_cnt(2'd2);
    run_cmd(1'b0, 1'b1, 4'd0);
    check("t4_ready_pulses", 32'(r_rdy), 1);
    check("t4_en_cycles", 32'(r_en), 0);
    check("t4_latency", 32'(r_lat), 1);
    check("t4_done_sat", 32'(r_sat), 0);
    check("t4_done_q", 32'(r_q), 2);

    // Test 6: down 15 from 0 saturates immediately; req1 waits for IDLE
    load_cnt(2'd0);
    req0_valid = 1; req0_dir = 0; req0_steps = 4'd15;
    #0;
    check("t6_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_dir = 1; req1_steps = 4'd1;
    #0;
    check("t6_busy", 32'(busy), 1);
    check("t6_no_en", 32'(cnt_en), 0);
    check("t6_rdy1_run", 32'(req1_ready), 0);
    tick();
    check("t6_done", 32'(done), 1);
    check("t6_done_sat", 32'(done_sat), 1);
    check("t6_done_q", 32'(done_q), 0);
    check("t6_rdy1_done", 32'(req1_ready), 0);
    tick();
    check("t6_rdy1_idle", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    wait_done();
    tick();

    // Test 5: reset in the second RUN cycle of a 4-step command
    load_cnt(2'd0);
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd4;
    #0;
    check("t5_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    tick();
    check("t5_en_run2", 32'(cnt_en), 1);
    check("t5_busy_run2", 32'(busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_en_after_rst", 32'(cnt_en), 0);
    check("t5_busy_after_rst", 32'(busy), 0);
    check("t5_done_after_rst", 32'(done), 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      tick();
    end
    check("t5_no_done_pulse", 32'(ndone), 0);
    load_cnt(2'd0);
    req0_valid = 1; req0_dir = 1; req0_steps = 4'd1;
    req1_valid = 1; req1_dir = 1; req1_steps = 4'd1;
    #0;
    check("t5_rr_zero_rdy0", 32'(req0_ready), 1);
    check("t5_rr_zero_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_done();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
